pattern_monitor: RTL and testbench

Observer for a 10-bit LED pattern bus driven by the up/down counter pattern generators. Samples the bus every clock and recovers the generator's direction, step size and tick period. Locks once the pattern behaves as a steady counter and flags any deviation afterwards. Sits beside the LED drivers as an on-board self-check, and is reused in benches as the scoreboard for pattern generators.

---
 rtl/pattern_monitor.sv | 183 ++++++++++++++++++
 tb/tb_pattern_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_monitor.sv
// pattern_monitor: recovers direction, step and tick period of an up/down counter LED pattern,
// locks onto a steady counter and flags deviations. Stall watchdog: define PATTERN_MONITOR_WDOG_EN.
`timescale 1ns/1ps
module pattern_monitor #(
  parameter int PERIOD_BITS = 26,
  parameter int LOCK_COUNT  = 4,
  parameter int WDOG_MULT   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [9:0]             pattern,
  output logic                   locked,
  output logic                   dir_up,
  output logic [9:0]             step,
  output logic [PERIOD_BITS-1:0] period,
  output logic                   fault,
  output logic                   fault_sticky
);

  // state   | meaning
  // IDLE    | disabled or just reset; gap held at 0
  // PRIME   | waiting for the first change to seed the reference
  // ACQUIRE | counting changes that match the reference
  // LOCKED  | steady counter seen; mismatches raise fault
  typedef enum logic [1:0] {IDLE, PRIME, ACQUIRE, LOCKED} state_t;

  localparam logic [PERIOD_BITS-1:0] GAP_MAX     = '1;
  localparam logic [PERIOD_BITS-1:0] GAP_ONE     = {{(PERIOD_BITS-1){1'b0}}, 1'b1};
  localparam logic [PERIOD_BITS-1:0] WDOG_MULT_V = PERIOD_BITS'(WDOG_MULT);
  localparam logic [3:0]             LOCK_LAST   = 4'(LOCK_COUNT - 1);

`ifdef PATTERN_MONITOR_WDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  state_t                   state, state_nxt;
  logic [9:0]               pat_q, last_q;
  logic [PERIOD_BITS-1:0]   gap;
  logic [3:0]               match_cnt;

  logic                     change;
  logic [9:0]               delta;
  logic                     meas_up;
  logic [9:0]               meas_step;
  logic                     meas_sat;
  logic [PERIOD_BITS-1:0]   meas_period;
  logic                     match;

  logic [2*PERIOD_BITS-1:0] wdog_prod;
  logic [PERIOD_BITS-1:0]   wdog_limit;
  logic                     wdog_hit;

  logic                     load_ref, cnt_clr, cnt_inc, fault_nxt, gap_clr, last_load;

  assign change      = pat_q != last_q;
  assign delta       = pat_q - last_q;
  // a half-scale jump of 512 is classified as up
  assign meas_up     = delta <= 10'd512;
  assign meas_step   = meas_up ? delta : 10'd0 - delta;
  assign meas_sat    = gap == GAP_MAX;
  assign meas_period = meas_sat ? GAP_MAX : gap + GAP_ONE;
  // a saturated interval is not a real period, so it never counts as a match
  assign match       = (meas_up == dir_up) && (meas_step == step) &&
                       (meas_period == period) && !meas_sat;

  assign wdog_prod  = {{PERIOD_BITS{1'b0}}, WDOG_MULT_V} * {{PERIOD_BITS{1'b0}}, period};
  assign wdog_limit = (|wdog_prod[2*PERIOD_BITS-1:PERIOD_BITS]) ? GAP_MAX
                                                                : wdog_prod[PERIOD_BITS-1:0];
  assign wdog_hit   = WDOG_EN && (gap >= wdog_limit);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = PRIME;
        PRIME:   if (change) state_nxt = ACQUIRE;
        ACQUIRE: begin
          if (change && match && match_cnt == LOCK_LAST) state_nxt = LOCKED;
        end
        LOCKED: begin
          if (change) begin
            if (!match) state_nxt = ACQUIRE;
          end else if (wdog_hit) begin
            state_nxt = PRIME;
          end
        end
      endcase
    end
  end

  always_comb begin
    load_ref  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    fault_nxt = 1'b0;
    gap_clr   = !en;
    last_load = 1'b0;
    if (en) begin
      case (state)
        IDLE: begin
          gap_clr   = 1'b1;
          last_load = 1'b1;
        end
        PRIME: begin
          if (change) begin
            load_ref  = 1'b1;
            cnt_clr   = 1'b1;
            gap_clr   = 1'b1;
            last_load = 1'b1;
          end
        end
        ACQUIRE: begin
          if (change) begin
            gap_clr   = 1'b1;
            last_load = 1'b1;
            if (match) begin
              cnt_inc = 1'b1;
            end else begin
              load_ref = 1'b1;
              cnt_clr  = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (change) begin
            gap_clr   = 1'b1;
            last_load = 1'b1;
            if (!match) begin
              load_ref  = 1'b1;
              cnt_clr   = 1'b1;
              fault_nxt = 1'b1;
            end
          end else if (wdog_hit) begin
            // stalled bus: re-prime from the value already held in last_q
            fault_nxt = 1'b1;
            gap_clr   = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q        <= '0;
      last_q       <= '0;
      gap          <= '0;
      match_cnt    <= '0;
      locked       <= 1'b0;
      dir_up       <= 1'b1;
      step         <= '0;
      period       <= '0;
      fault        <= 1'b0;
      fault_sticky <= 1'b0;
    end else begin
      pat_q  <= pattern;
      locked <= state_nxt == LOCKED;
      fault  <= fault_nxt;
      if (fault_nxt) fault_sticky <= 1'b1;
      if (last_load) last_q <= pat_q;
      if (gap_clr)        gap <= '0;
      else if (!meas_sat) gap <= gap + GAP_ONE;
      if (cnt_clr)      match_cnt <= '0;
      else if (cnt_inc) match_cnt <= match_cnt + 4'd1;
      if (load_ref) begin
        dir_up <= meas_up;
        step   <= meas_step;
        period <= meas_period;
      end
    end
  end

endmodule

// File: tb/tb_pattern_monitor.sv
// Bench for pattern_monitor: directed scenarios plus randomized generator segments, all
// compared every cycle against an event-level reference model.
`timescale 1ns/1ps
module tb_pattern_monitor;
  localparam int PB   = 8;
  localparam int LC   = 4;
  localparam int WM   = 4;
  localparam int PMAX = (1 << PB) - 1;
  localparam int M_IDLE = 0, M_PRIME = 1, M_ACQ = 2, M_LOCK = 3;

  logic          clk = 1'b0;
  logic          rst, en;
  logic [9:0]    pattern;
  logic          locked, dir_up, fault, fault_sticky;
  logic [9:0]    step;
  logic [PB-1:0] period;

  pattern_monitor #(.PERIOD_BITS(PB), .LOCK_COUNT(LC), .WDOG_MULT(WM)) dut (
    .clk(clk), .rst(rst), .en(en), .pattern(pattern), .locked(locked), .dir_up(dir_up),
    .step(step), .period(period), .fault(fault), .fault_sticky(fault_sticky)
  );

  always #10 clk = ~clk;

  int n_checks = 0, n_errors = 0, fault_seen = 0, fault_base;
  logic [9:0] val;

  // reference: a change is timestamped; period is the edge distance between processed events
  int     m_mode, m_last, m_patq, m_step, m_per, m_cnt;
  bit     m_dir, m_fault, m_sticky;
  longint cyc = 0, t_ref = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input int p);
    int d, s, meas, lim;
    bit up, match;
    cyc++;
    m_fault = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_last = 0; m_patq = 0; m_dir = 1'b1; m_step = 0; m_per = 0;
      m_sticky = 1'b0; m_cnt = 0; t_ref = cyc;
    end else begin
      lim = (WM * m_per > PMAX) ? PMAX : WM * m_per;
      if (!e) begin
        m_mode = M_IDLE; t_ref = cyc;
      end else if (m_mode == M_IDLE) begin
        m_last = m_patq; m_mode = M_PRIME; t_ref = cyc;
      end else if (m_patq != m_last) begin
        d    = (m_patq - m_last + 1024) % 1024;
        up   = d <= 512;
        s    = up ? d : 1024 - d;
        meas = (cyc - t_ref > PMAX) ? PMAX : int'(cyc - t_ref);
        match = (up == m_dir) && (s == m_step) && (meas == m_per) && (meas != PMAX);
        if (m_mode == M_PRIME || !match) begin
          if (m_mode == M_LOCK) begin m_fault = 1'b1; m_sticky = 1'b1; end
          m_dir = up; m_step = s; m_per = meas; m_cnt = 0; m_mode = M_ACQ;
        end else if (m_mode == M_ACQ) begin
          m_cnt++;
          if (m_cnt == LC) m_mode = M_LOCK;
        end
        m_last = m_patq; t_ref = cyc;
      end
`ifdef PATTERN_MONITOR_WDOG_EN
      else if (m_mode == M_LOCK && (cyc - 1 - t_ref) >= lim) begin
        m_fault = 1'b1; m_sticky = 1'b1; m_mode = M_PRIME; t_ref = cyc;
      end
`endif
      m_patq = p;
    end
  endtask

  function automatic logic [31:0] exp_vec();
    logic [31:0] v = '0;
    v[21]    = (m_mode == M_LOCK);
    v[20]    = m_dir;
    v[19:10] = m_step[9:0];
    v[9:2]   = m_per[7:0];
    v[1]     = m_fault;
    v[0]     = m_sticky;
    return v;
  endfunction

  function automatic logic [31:0] got_vec();
    return {10'b0, locked, dir_up, step, period, fault, fault_sticky};
  endfunction

  task automatic cycle(input bit r, input bit e, input logic [9:0] p);
    rst = r; en = e; pattern = p;
    @(posedge clk);
    model_edge(r, e, int'(p));
    #1;
    if (fault) fault_seen++;
    check("outputs", got_vec(), exp_vec());
  endtask

  task automatic hold(input int n);
    repeat (n) cycle(1'b0, 1'b1, val);
  endtask

  task automatic gen(input bit up, input logic [9:0] st, input int per, input int n);
    repeat (n) begin
      val = up ? val + st : val - st;
      repeat (per) cycle(1'b0, 1'b1, val);
    end
  endtask

  // leaves the monitor just entered PRIME with val already sitting in last_q
  task automatic do_reset(input logic [9:0] v);
    val = v;
    cycle(1'b1, 1'b0, val);
    check("reset_vals", got_vec(), 32'h0010_0000);
    cycle(1'b1, 1'b0, val);
    cycle(1'b0, 1'b0, val);
    cycle(1'b0, 1'b1, val);
  endtask

  initial begin
    // up count, step 1, period 16
    do_reset(10'd0);
    hold(14);
    gen(1'b1, 10'd1, 16, 4);
    check("up1_prelock", {31'b0, locked}, 32'd0);
    gen(1'b1, 10'd1, 16, 1);
    check("up1_locked", got_vec(), {10'b0, 1'b1, 1'b1, 10'd1, 8'd16, 1'b0, 1'b0});
    check("up1_no_fault", fault_seen, 0);

    // step change while locked, then relock on step 2
    gen(1'b1, 10'd2, 16, 1);
    check("step_fault_once", fault_seen, 1);
    check("step_unlock", {30'b0, locked, fault_sticky}, 32'b01);
    gen(1'b1, 10'd2, 16, 3);
    check("step_prelock", {31'b0, locked}, 32'd0);
    gen(1'b1, 10'd2, 16, 1);
    check("step_relock", got_vec(), {10'b0, 1'b1, 1'b1, 10'd2, 8'd16, 1'b0, 1'b1});

    // one late tick (17 clocks)
    hold(1);
    gen(1'b1, 10'd2, 16, 1);
    check("late_fault", fault_seen, 2);
    check("late_period", {30'b0, locked, fault_sticky}, 32'b01);
    check("late_per_val", {24'b0, period}, 32'd17);
    cycle(1'b1, 1'b1, val);
    check("late_reset", got_vec(), 32'h0010_0000);

    // down count, step 3, period 8, wrapping 2 -> 1023 -> 1020
    fault_base = fault_seen;
    do_reset(10'd14);
    hold(6);
    gen(1'b0, 10'd3, 8, 6);
    check("down_val", {22'b0, val}, 32'd1020);
    check("down_locked", got_vec(), {10'b0, 1'b1, 1'b0, 10'd3, 8'd8, 1'b0, 1'b0});
    check("down_no_fault", fault_seen, fault_base);

    // en dropped mid-LOCKED
    repeat (10) cycle(1'b0, 1'b0, val);
    check("en_unlock", {30'b0, locked, fault_sticky}, 32'b00);
    check("en_no_fault", fault_seen, fault_base);
    cycle(1'b0, 1'b1, val);
    hold(6);
    gen(1'b0, 10'd3, 8, 4);
    check("en_prelock", {31'b0, locked}, 32'd0);
    gen(1'b0, 10'd3, 8, 1);
    check("en_relock", {31'b0, locked}, 32'd1);

    // frozen bus while locked
    hold(1000);
`ifdef PATTERN_MONITOR_WDOG_EN
    check("freeze_wdog", {30'b0, locked, fault_sticky}, 32'b01);
    check("freeze_wdog_once", fault_seen, fault_base + 1);
`else
    check("freeze_locked", {30'b0, locked, fault_sticky}, 32'b10);
    check("freeze_no_fault", fault_seen, fault_base);
`endif

    // saturated interval accepted in PRIME
    do_reset(10'd0);
    hold(300);
    gen(1'b1, 10'd1, 16, 1);
    check("sat_prime", {22'b0, dir_up, step[0], period}, {22'b0, 1'b1, 1'b1, 8'd255});

    // half-scale boundary: 512 is up, 513 is down 511
    do_reset(10'd0);
    hold(14);
    gen(1'b1, 10'd512, 16, 1);
    check("half_up", {21'b0, dir_up, step}, {21'b0, 1'b1, 10'd512});
    gen(1'b1, 10'd513, 16, 1);
    check("half_down", {21'b0, dir_up, step}, {21'b0, 1'b0, 10'd511});

    // randomized generator segments with resets, enable drops and glitches
    for (int seg = 0; seg < 60; seg++) begin
      int kind, per, ticks;
      logic [9:0] st;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        cycle(1'b1, 1'($urandom_range(0, 1)), val);
      end else if (kind == 1) begin
        repeat ($urandom_range(1, 12)) cycle(1'b0, 1'b0, val);
      end else if (kind == 2) begin
        val = 10'($urandom);
        hold($urandom_range(1, 5));
      end else begin
        case ($urandom_range(0, 3))
          0:       st = 10'd1;
          1:       st = 10'd512;
          default: st = 10'($urandom_range(1, 512));
        endcase
        per   = $urandom_range(2, 20);
        ticks = $urandom_range(1, 8);
        hold($urandom_range(0, per));
        gen(1'($urandom_range(0, 1)), st, per, ticks);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
